// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end.
// Owns the fetch PC, issues one word request at a time to a variable-latency
// instruction memory, and buffers returned instructions (with their PCs) in
// a small circular queue that feeds the IF/ID register. A taken branch from
// MEM flushes everything in flight and restarts fetch at the branch target.
module instr_fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [XLEN-1:0]        imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [31:0]            deq_instr,
  output logic [XLEN-1:0]        deq_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // DROP waits out a request that a redirect made stale
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic            req_next;
  logic [XLEN-1:0] addr_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fetch_pc_next;
  logic [XLEN-1:0] addr_plus4;
  logic [XLEN-1:0] redirect_target;

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic            ack_fire;
  logic            flush;
  logic            enq;
  logic            deq;

  // Acks only count while a request is actually outstanding
  assign ack_fire        = imem_req & imem_ack;
  assign flush           = redirect_valid;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
  assign addr_plus4      = imem_addr + XLEN'(4);

  // A redirect beats both enqueue and dequeue in the same cycle; data
  // returned in DROP is never enqueued
  assign deq_valid = (count != '0);
  assign deq       = deq_valid & deq_ready & ~flush;
  assign enq       = (state == REQ) & ack_fire & ~flush;

  assign deq_instr = instr_mem[rd_ptr];
  assign deq_pc    = pc_mem[rd_ptr];

  // Occupancy after this cycle's enqueue/dequeue/flush
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      unique case ({enq, deq})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  // Fetch FSM next-state and registered-output computation
  always_comb begin
    state_next    = state;
    req_next      = imem_req;
    addr_next     = imem_addr;
    fetch_pc_next = fetch_pc;
    unique case (state)
      IDLE: begin
        if (flush) begin
          fetch_pc_next = redirect_target;
        end else if (count < FULL) begin
          state_next = REQ;
          req_next   = 1'b1;
          addr_next  = fetch_pc;
        end
      end
      REQ: begin
        if (flush) begin
          fetch_pc_next = redirect_target;
          if (ack_fire) begin
            state_next = IDLE;
            req_next   = 1'b0;
          end else begin
            state_next = DROP;
          end
        end else if (ack_fire) begin
          fetch_pc_next = addr_plus4;
          if (count_next < FULL) begin
            addr_next = addr_plus4;
          end else begin
            state_next = IDLE;
            req_next   = 1'b0;
          end
        end
      end
      DROP: begin
        if (flush) begin
          fetch_pc_next = redirect_target;
        end
        if (ack_fire) begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  // Fetch FSM state, request and PC registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
    end else begin
      state     <= state_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
      fetch_pc  <= fetch_pc_next;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue outright
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
    end
  end

  // Store the returned instruction with the address it was fetched from
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (enq) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= imem_addr;
    end
  end

  // Issue is gated on free space and only one request is ever in flight,
  // so an enqueue into a full queue means the gating logic is broken
  assert property (@(posedge clk) disable iff (!reset) enq |-> (count != FULL));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios push expected
// head PCs into a queue, a negedge monitor pops and compares on each dequeue.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  logic                   clk;
  logic                   reset;

  logic                   imem_req;
  logic [XLEN-1:0]        imem_addr;
  logic                   imem_ack;
  logic [31:0]            imem_rdata;
  logic                   redirect_valid;
  logic [XLEN-1:0]        redirect_pc;
  logic                   deq_valid;
  logic                   deq_ready;
  logic [31:0]            deq_instr;
  logic [XLEN-1:0]        deq_pc;
  logic [$clog2(DEPTH):0] count;

  logic                   w_imem_req;
  logic [XLEN-1:0]        w_imem_addr;
  logic                   w_imem_ack;
  logic [31:0]            w_imem_rdata;
  logic                   w_redirect_valid;
  logic [XLEN-1:0]        w_redirect_pc;
  logic                   w_deq_valid;
  logic                   w_deq_ready;
  logic [31:0]            w_deq_instr;
  logic [XLEN-1:0]        w_deq_pc;
  logic [$clog2(DEPTH):0] w_count;

  int unsigned            mem_lat;
  int unsigned            wait_cnt;
  logic                   force_ack;

  logic [63:0]            exp_q[$];
  logic [63:0]            exp_w_q[$];

  int                     compared;
  int                     mismatched;
  logic [$clog2(DEPTH):0] max_count;
  bit                     track_max;

  // Instruction word the memory model returns for a given address
  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hC0DE_0000;
  endfunction

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(64'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_instr      (deq_instr),
    .deq_pc         (deq_pc),
    .count          (count)
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(WRAP_PC)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_ack       (w_imem_ack),
    .imem_rdata     (w_imem_rdata),
    .redirect_valid (w_redirect_valid),
    .redirect_pc    (w_redirect_pc),
    .deq_valid      (w_deq_valid),
    .deq_ready      (w_deq_ready),
    .deq_instr      (w_deq_instr),
    .deq_pc         (w_deq_pc),
    .count          (w_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ack after mem_lat waiting cycles; force_ack drives a
  // spurious ack regardless of request
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack     = force_ack | (imem_req && (wait_cnt >= mem_lat));
  assign imem_rdata   = instr_of(imem_addr);

  assign w_imem_ack       = w_imem_req;
  assign w_imem_rdata     = instr_of(w_imem_addr);
  assign w_redirect_valid = 1'b0;
  assign w_redirect_pc    = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [63:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    deq_ready      = rdy;
  endtask

  // Main scoreboard monitor
  always @(negedge clk) begin
    if (reset && track_max && (count > max_count)) max_count = count;
    if (reset && deq_valid && deq_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_deq: actual pc=%h required=no dequeue", deq_pc);
      end else begin
        logic [63:0] pc;
        pc = exp_q.pop_front();
        checkOutput("deq_pc", deq_pc, pc);
        checkOutput("deq_instr", 64'(deq_instr), 64'(instr_of(pc)));
      end
    end
  end

  // Scoreboard monitor for the wrap-around instance
  always @(negedge clk) begin
    if (reset && w_deq_valid && w_deq_ready) begin
      if (exp_w_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_wrap_deq: actual pc=%h required=no dequeue", w_deq_pc);
      end else begin
        logic [63:0] pc;
        pc = exp_w_q.pop_front();
        checkOutput("wrap_deq_pc", w_deq_pc, pc);
        checkOutput("wrap_deq_instr", 64'(w_deq_instr), 64'(instr_of(pc)));
      end
    end
  end

  function automatic int qsize(input bit which);
    return which ? exp_w_q.size() : exp_q.size();
  endfunction

  task automatic waitDrain(input string name, input bit which, input int limit);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, 64'(qsize(which)), 64'd0);
    if (which) exp_w_q.delete();
    else       exp_q.delete();
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    compared    = 0;
    mismatched  = 0;
    max_count   = '0;
    track_max   = 1'b0;
    mem_lat     = 0;
    force_ack   = 1'b0;
    w_deq_ready = 1'b0;
    applyStimulus(1'b0, 64'd0, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    checkOutput("rst_imem_req", 64'(imem_req), 64'd0);
    checkOutput("rst_imem_addr", imem_addr, 64'd0);
    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_deq_valid", 64'(deq_valid), 64'd0);
    checkOutput("rst_deq_pc", deq_pc, 64'd0);
    checkOutput("rst_deq_instr", 64'(deq_instr), 64'd0);
    checkOutput("rst_wrap_imem_addr", w_imem_addr, WRAP_PC);
    @(posedge clk);
    #1 reset = 1'b1;

    // Zero-wait streaming with IF/ID always ready
    $display("[TB] scenario: zero-wait streaming");
    applyStimulus(1'b0, 64'd0, 1'b1);
    track_max = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back(64'(i * 4));
    @(posedge clk);
    @(negedge clk);
    checkOutput("s1_first_req", 64'(imem_req), 64'd1);
    checkOutput("s1_first_addr", imem_addr, 64'd0);
    checkOutput("s1_deq_valid_early", 64'(deq_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s1_deq_valid_fill", 64'(deq_valid), 64'd1);
    waitDrain("s1_drain", 1'b0, 30);
    applyStimulus(1'b0, 64'd0, 1'b0);
    track_max = 1'b0;
    checkOutput("s1_max_count_le2", 64'(max_count <= 2), 64'd1);

    // Stall until full, spurious acks ignored, then release
    $display("[TB] scenario: stall until full");
    pulseReset();
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("s2_count_full", 64'(count), 64'd4);
    checkOutput("s2_req_dropped", 64'(imem_req), 64'd0);
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("s2_count_after_stray_ack", 64'(count), 64'd4);
    checkOutput("s2_req_still_low", 64'(imem_req), 64'd0);
    force_ack = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) exp_q.push_back(64'(i * 4));
    applyStimulus(1'b0, 64'd0, 1'b1);
    waitDrain("s2_drain", 1'b0, 40);
    applyStimulus(1'b0, 64'd0, 1'b0);

    // Redirect while a slow request is outstanding
    $display("[TB] scenario: redirect during memory wait");
    pulseReset();
    mem_lat = 3;
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 64'h100, 1'b1);
    exp_q.push_back(64'h100);
    exp_q.push_back(64'h104);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("s3_count_flushed", 64'(count), 64'd0);
    checkOutput("s3_deq_valid_flushed", 64'(deq_valid), 64'd0);
    checkOutput("s3_drop_req_held", 64'(imem_req), 64'd1);
    checkOutput("s3_drop_addr_held", imem_addr, 64'd0);
    n = 0;
    while (!(imem_req && imem_addr != 64'd0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("s3_refetch_addr", imem_addr, 64'h100);
    waitDrain("s3_drain", 1'b0, 60);
    applyStimulus(1'b0, 64'd0, 1'b0);
    mem_lat = 0;

    // Redirect coinciding with an ack and a dequeue; target is misaligned
    $display("[TB] scenario: redirect with ack and dequeue");
    pulseReset();
    applyStimulus(1'b0, 64'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1'b1, 64'h203, 1'b1);
    @(negedge clk);
    checkOutput("s4_setup_deq_valid", 64'(deq_valid), 64'd1);
    checkOutput("s4_setup_ack", 64'(imem_ack), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 64'd0, 1'b1);
    @(negedge clk);
    checkOutput("s4_count_zero", 64'(count), 64'd0);
    checkOutput("s4_deq_valid_zero", 64'(deq_valid), 64'd0);
    checkOutput("s4_req_idle", 64'(imem_req), 64'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("s4_req_restart", 64'(imem_req), 64'd1);
    checkOutput("s4_aligned_addr", imem_addr, 64'h200);
    exp_q.push_back(64'h200);
    exp_q.push_back(64'h204);
    waitDrain("s4_drain", 1'b0, 20);
    applyStimulus(1'b0, 64'd0, 1'b0);

    // PC wrap-around from the top of the address space
    $display("[TB] scenario: PC wrap");
    pulseReset();
    w_deq_ready = 1'b1;
    exp_w_q.push_back(64'hFFFF_FFFF_FFFF_FFF8);
    exp_w_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_w_q.push_back(64'h0);
    exp_w_q.push_back(64'h4);
    waitDrain("s5_wrap_drain", 1'b1, 20);
    w_deq_ready = 1'b0;

    // Asynchronous reset in the middle of a request
    $display("[TB] scenario: async reset mid-request");
    pulseReset();
    applyStimulus(1'b0, 64'd0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("s6_pre_count", 64'(count), 64'd3);
    checkOutput("s6_pre_req", 64'(imem_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("s6_count_cleared", 64'(count), 64'd0);
    checkOutput("s6_deq_valid_cleared", 64'(deq_valid), 64'd0);
    checkOutput("s6_req_cleared", 64'(imem_req), 64'd0);
    checkOutput("s6_addr_reset", imem_addr, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("s6_restart_req", 64'(imem_req), 64'd1);
    checkOutput("s6_restart_addr", imem_addr, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
